// File: rtl/tlv5618_frame_receiver.sv
// TLV5618 serial-frame receiver: oversamples nCS/SCLK/DIN on Clk, rebuilds 16-bit frames
// and mirrors the DAC register state. Optional expectation checker: TLV5618_RX_CHECK_EN.
module tlv5618_frame_receiver (
  input  logic        Clk,
  input  logic        reset_n,
  input  logic        nCS,
  input  logic        SCLK,
  input  logic        DIN,
`ifdef TLV5618_RX_CHECK_EN
  input  logic [11:0] ExpectDacA,
  input  logic [11:0] ExpectDacB,
  output logic        Mismatch,
`endif
  output logic [11:0] DacAValue,
  output logic [11:0] DacBValue,
  output logic [11:0] BufferValue,
  output logic        Speed,
  output logic        PowerDown,
  output logic [15:0] FrameWord,
  output logic        FrameValid,
  output logic        FrameError,
  output logic [1:0]  ErrorCode,
  output logic [15:0] FrameCount
);

  typedef enum logic [1:0] {IDLE, SHIFT, DECODE} state_t;

  logic ncs_s1_q, ncs_s2_q, ncs_h_q;
  logic sclk_s1_q, sclk_s2_q, sclk_h_q;
  logic din_s1_q, din_s2_q;
  logic ncs_fall, ncs_rise, sclk_fall;

  state_t      state_q, state_d;
  logic [15:0] shift_q, shift_d;
  logic [4:0]  bitcnt_q, bitcnt_d;
  logic [11:0] daca_q, daca_d, dacb_q, dacb_d, buf_q, buf_d;
  logic        spd_q, spd_d, pwr_q, pwr_d;
  logic [15:0] fword_q, fword_d;
  logic        fvalid_q, fvalid_d, ferr_q, ferr_d;
  logic [1:0]  ecode_q, ecode_d;
  logic [15:0] fcnt_q, fcnt_d;

  // DIN needs no history FF: only its level is sampled, on an SCLK falling edge.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      ncs_s1_q  <= 1'b1;
      ncs_s2_q  <= 1'b1;
      ncs_h_q   <= 1'b1;
      sclk_s1_q <= 1'b1;
      sclk_s2_q <= 1'b1;
      sclk_h_q  <= 1'b1;
      din_s1_q  <= 1'b0;
      din_s2_q  <= 1'b0;
    end else begin
      ncs_s1_q  <= nCS;
      ncs_s2_q  <= ncs_s1_q;
      ncs_h_q   <= ncs_s2_q;
      sclk_s1_q <= SCLK;
      sclk_s2_q <= sclk_s1_q;
      sclk_h_q  <= sclk_s2_q;
      din_s1_q  <= DIN;
      din_s2_q  <= din_s1_q;
    end
  end

  assign ncs_fall  = ~ncs_s2_q & ncs_h_q;
  assign ncs_rise  = ncs_s2_q & ~ncs_h_q;
  assign sclk_fall = ~sclk_s2_q & sclk_h_q;

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      bitcnt_q <= '0;
      daca_q   <= '0;
      dacb_q   <= '0;
      buf_q    <= '0;
      spd_q    <= 1'b0;
      pwr_q    <= 1'b0;
      fword_q  <= '0;
      fvalid_q <= 1'b0;
      ferr_q   <= 1'b0;
      ecode_q  <= '0;
      fcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      bitcnt_q <= bitcnt_d;
      daca_q   <= daca_d;
      dacb_q   <= dacb_d;
      buf_q    <= buf_d;
      spd_q    <= spd_d;
      pwr_q    <= pwr_d;
      fword_q  <= fword_d;
      fvalid_q <= fvalid_d;
      ferr_q   <= ferr_d;
      ecode_q  <= ecode_d;
      fcnt_q   <= fcnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    bitcnt_d = bitcnt_q;
    daca_d   = daca_q;
    dacb_d   = dacb_q;
    buf_d    = buf_q;
    spd_d    = spd_q;
    pwr_d    = pwr_q;
    fword_d  = fword_q;
    fvalid_d = 1'b0;
    ferr_d   = 1'b0;
    ecode_d  = ecode_q;
    fcnt_d   = fcnt_q;
    case (state_q)
      IDLE: begin
        if (ncs_fall) begin
          shift_d  = '0;
          bitcnt_d = '0;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        // A falling SCLK coincident with nCS rising still belongs to this frame.
        if (sclk_fall) begin
          shift_d = {shift_q[14:0], din_s2_q};
          if (bitcnt_q != 5'd17) bitcnt_d = bitcnt_q + 5'd1;
        end
        if (ncs_rise) state_d = DECODE;
      end
      DECODE: begin
        state_d = IDLE;
        if (bitcnt_q != 5'd16) begin
          ferr_d  = 1'b1;
          ecode_d = 2'b01;
        end else begin
          fword_d = shift_q;
          if (shift_q[15] & shift_q[12]) begin
            ferr_d  = 1'b1;
            ecode_d = 2'b10;
          end else begin
            case ({shift_q[15], shift_q[12]})
              2'b00: begin
                dacb_d = shift_q[11:0];
                buf_d  = shift_q[11:0];
              end
              2'b01: buf_d = shift_q[11:0];
              default: begin
                daca_d = shift_q[11:0];
                dacb_d = buf_q;
              end
            endcase
            spd_d    = shift_q[14];
            pwr_d    = shift_q[13];
            fvalid_d = 1'b1;
            fcnt_d   = fcnt_q + 16'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef TLV5618_RX_CHECK_EN
  logic mismatch_q;

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) mismatch_q <= 1'b0;
    else if (fvalid_q) mismatch_q <= (daca_q != ExpectDacA) | (dacb_q != ExpectDacB);
  end

  assign Mismatch = mismatch_q;
`endif

  assign DacAValue   = daca_q;
  assign DacBValue   = dacb_q;
  assign BufferValue = buf_q;
  assign Speed       = spd_q;
  assign PowerDown   = pwr_q;
  assign FrameWord   = fword_q;
  assign FrameValid  = fvalid_q;
  assign FrameError  = ferr_q;
  assign ErrorCode   = ecode_q;
  assign FrameCount  = fcnt_q;

endmodule

// File: tb/tb_tlv5618_frame_receiver.sv
// Directed bench for tlv5618_frame_receiver; define TLV5618_RX_CHECK_EN to also exercise Mismatch.
module tb_tlv5618_frame_receiver;

  logic        Clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        nCS = 1'b1;
  logic        SCLK = 1'b1;
  logic        DIN = 1'b0;
  logic [11:0] DacAValue, DacBValue, BufferValue;
  logic        Speed, PowerDown, FrameValid, FrameError;
  logic [15:0] FrameWord, FrameCount;
  logic [1:0]  ErrorCode;
`ifdef TLV5618_RX_CHECK_EN
  logic [11:0] ExpectDacA = '0;
  logic [11:0] ExpectDacB = '0;
  logic        Mismatch;
`endif

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 Clk = ~Clk;

  tlv5618_frame_receiver dut (
    .Clk         (Clk),
    .reset_n     (reset_n),
    .nCS         (nCS),
    .SCLK        (SCLK),
    .DIN         (DIN),
`ifdef TLV5618_RX_CHECK_EN
    .ExpectDacA  (ExpectDacA),
    .ExpectDacB  (ExpectDacB),
    .Mismatch    (Mismatch),
`endif
    .DacAValue   (DacAValue),
    .DacBValue   (DacBValue),
    .BufferValue (BufferValue),
    .Speed       (Speed),
    .PowerDown   (PowerDown),
    .FrameWord   (FrameWord),
    .FrameValid  (FrameValid),
    .FrameError  (FrameError),
    .ErrorCode   (ErrorCode),
    .FrameCount  (FrameCount)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge Clk);
    reset_n = 1'b0;
    nCS     = 1'b1;
    SCLK    = 1'b1;
    DIN     = 1'b0;
    repeat (3) @(negedge Clk);
    reset_n = 1'b1;
    repeat (3) @(negedge Clk);
  endtask

  task automatic shift_bits(input logic [15:0] w, input int unsigned nbits);
    for (int unsigned i = 0; i < nbits; i++) begin
      DIN = (i < 16) ? w[4'(15 - i)] : 1'b0;
      repeat (4) @(negedge Clk);
      SCLK = 1'b0;
      repeat (4) @(negedge Clk);
      SCLK = 1'b1;
    end
  endtask

  // Sends a frame and checks the pulse timing: nothing on edges 1-3 after nCS rises,
  // the expected pulse on edge 4, nothing on edge 5.
  task automatic send_frame(input string tag, input logic [15:0] w, input int unsigned nbits,
                            input logic want_valid);
    logic early, v4, e4, late;
    @(negedge Clk);
    nCS = 1'b0;
    repeat (4) @(negedge Clk);
    shift_bits(w, nbits);
    repeat (4) @(negedge Clk);
    nCS = 1'b1;
    early = 1'b0;
    repeat (3) begin
      @(posedge Clk); #1;
      early |= FrameValid | FrameError;
    end
    @(posedge Clk); #1;
    v4 = FrameValid;
    e4 = FrameError;
    @(posedge Clk); #1;
    late = FrameValid | FrameError;
    check_eq({tag, "_early"}, 32'(early), 32'd0);
    check_eq({tag, "_valid"}, 32'(v4), 32'(want_valid));
    check_eq({tag, "_error"}, 32'(e4), 32'(!want_valid));
    check_eq({tag, "_late"}, 32'(late), 32'd0);
    repeat (6) @(negedge Clk);
  endtask

  task automatic check_regs(input string tag, input logic [11:0] a, input logic [11:0] b,
                            input logic [11:0] bf, input logic spd, input logic pwr,
                            input logic [15:0] fw, input logic [15:0] cnt);
    check_eq({tag, "_daca"}, 32'(DacAValue), 32'(a));
    check_eq({tag, "_dacb"}, 32'(DacBValue), 32'(b));
    check_eq({tag, "_buf"}, 32'(BufferValue), 32'(bf));
    check_eq({tag, "_spd"}, 32'(Speed), 32'(spd));
    check_eq({tag, "_pwr"}, 32'(PowerDown), 32'(pwr));
    check_eq({tag, "_fword"}, 32'(FrameWord), 32'(fw));
    check_eq({tag, "_fcnt"}, 32'(FrameCount), 32'(cnt));
  endtask

  initial begin
    logic [15:0] cnt;
    do_reset();
    check_regs("rst", 12'h000, 12'h000, 12'h000, 1'b0, 1'b0, 16'h0000, 16'd0);
    check_eq("rst_fv", 32'(FrameValid), 32'd0);
    check_eq("rst_fe", 32'(FrameError), 32'd0);
    check_eq("rst_ec", 32'(ErrorCode), 32'd0);

    // SCLK activity with nCS high must be ignored
    shift_bits(16'hFFFF, 3);
    repeat (6) @(negedge Clk);
    check_eq("idle_sclk_fcnt", 32'(FrameCount), 32'd0);
    check_eq("idle_sclk_dacb", 32'(DacBValue), 32'd0);

    send_frame("f0ABC", 16'h0ABC, 16, 1'b1);
    check_regs("f0ABC", 12'h000, 12'hABC, 12'hABC, 1'b0, 1'b0, 16'h0ABC, 16'd1);

    do_reset();
`ifdef TLV5618_RX_CHECK_EN
    ExpectDacA = 12'h456;
    ExpectDacB = 12'h124;
`endif
    send_frame("f1123", 16'h1123, 16, 1'b1);
    check_regs("f1123", 12'h000, 12'h000, 12'h123, 1'b0, 1'b0, 16'h1123, 16'd1);
    send_frame("fC456", 16'hC456, 16, 1'b1);
    check_regs("fC456", 12'h456, 12'h123, 12'h123, 1'b1, 1'b0, 16'hC456, 16'd2);
    cnt = 16'd2;
`ifdef TLV5618_RX_CHECK_EN
    check_eq("mismatch_hi", 32'(Mismatch), 32'd1);
    ExpectDacB = 12'h123;
    send_frame("fC456b", 16'hC456, 16, 1'b1);
    cnt = 16'd3;
    check_eq("mismatch_lo", 32'(Mismatch), 32'd0);
`endif

    send_frame("short15", 16'h0555, 15, 1'b0);
    check_eq("short15_ec", 32'(ErrorCode), 32'd1);
    check_regs("short15", 12'h456, 12'h123, 12'h123, 1'b1, 1'b0, 16'hC456, cnt);
    send_frame("long17", 16'h0555, 17, 1'b0);
    check_eq("long17_ec", 32'(ErrorCode), 32'd1);
    check_regs("long17", 12'h456, 12'h123, 12'h123, 1'b1, 1'b0, 16'hC456, cnt);

    send_frame("f9FFF", 16'h9FFF, 16, 1'b0);
    check_eq("f9FFF_ec", 32'(ErrorCode), 32'd2);
    check_regs("f9FFF", 12'h456, 12'h123, 12'h123, 1'b1, 1'b0, 16'h9FFF, cnt);

    // Reset mid-frame: abort after 8 bits, then a fresh frame
    @(negedge Clk);
    nCS = 1'b0;
    repeat (4) @(negedge Clk);
    shift_bits(16'hC456, 8);
    do_reset();
    check_regs("midrst", 12'h000, 12'h000, 12'h000, 1'b0, 1'b0, 16'h0000, 16'd0);
    send_frame("f2800", 16'h2800, 16, 1'b1);
    check_regs("f2800", 12'h000, 12'h800, 12'h800, 1'b0, 1'b1, 16'h2800, 16'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
